descrypt_core_dispatch: RTL and testbench

Scheduler between the candidate-word stream and a bank of descrypt cores. Holds one candidate in a one-entry buffer. Selects a ready, non-dummy core in round-robin order, then writes the candidate into that core as `NUM_BEATS` addressed beats on the shared broadcast bus, with a one-hot per-core write enable. It also tracks which cores have just been loaded, reports aggregate idle, and flags core errors.

---
 rtl/descrypt_core_dispatch_if.sv | 24 ++
 rtl/descrypt_core_dispatch.sv | 79 +++++++
 tb/tb_descrypt_core_dispatch.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/descrypt_core_dispatch_if.sv
// descrypt_core_dispatch_if: candidate stream plus shared core load bus between dispatcher and core bank
interface descrypt_core_dispatch_if #(
  parameter int NUM_CORES = 16,
  parameter int DIN_WIDTH = 8,
  parameter int NUM_BEATS = 8
);
  logic [NUM_BEATS*DIN_WIDTH-1:0] din;
  logic wr_en;
  logic full;
  logic [NUM_CORES-1:0] crypt_ready_out;
  logic [NUM_CORES-1:0] core_idle_out;
  logic [NUM_CORES-1:0] core_err_out;
  logic [NUM_CORES-1:0] core_wr_en;
  logic [DIN_WIDTH-1:0] core_din;
  logic [2:0] core_addr_in;
  modport master (
    input  din, wr_en, crypt_ready_out, core_idle_out, core_err_out,
    output full, core_wr_en, core_din, core_addr_in
  );
  modport slave (
    output din, wr_en, crypt_ready_out, core_idle_out, core_err_out,
    input  full, core_wr_en, core_din, core_addr_in
  );
endinterface

// File: rtl/descrypt_core_dispatch.sv
// descrypt_core_dispatch: buffers one candidate and loads it beat by beat into a round-robin chosen core
module descrypt_core_dispatch #(
  parameter int NUM_CORES = 16,
  parameter int DIN_WIDTH = 8,
  parameter int NUM_BEATS = 8
) (
  input  logic CLK,
  input  logic rst,
  input  logic [NUM_CORES-1:0] DUMMY_CORES,
  descrypt_core_dispatch_if.master bus,
  output logic [31:0] num_dispatched,
  output logic idle,
  output logic [1:0] error
);
  localparam int GW = $clog2(NUM_CORES);
  typedef enum logic [1:0] {IDLE, SELECT, SEND} state_t;
  state_t state, state_nx;
  logic [NUM_BEATS*DIN_WIDTH-1:0] cand;
  logic [NUM_CORES-1:0] pending, eligible;
  logic [GW-1:0] last_grant, grant, pick;
  logic [2:0] nb;
  logic found, accept, start, step, done, last_beat;
  int idx;
  assign eligible = bus.crypt_ready_out & ~DUMMY_CORES & ~pending;
  assign bus.full = state != IDLE;
  assign last_beat = bus.core_addr_in == 3'(NUM_BEATS - 1);
  // first eligible core strictly after the previous grant, wrapping
  always_comb begin
    found = 1'b0;
    pick = '0;
    idx = 0;
    for (int i = 1; i <= NUM_CORES; i++) begin
      idx = int'(last_grant) + i;
      idx = idx >= NUM_CORES ? idx - NUM_CORES : idx;
      if (!found && eligible[GW'(idx)]) begin
        found = 1'b1;
        pick = GW'(idx);
      end
    end
  end
  always_comb begin
    accept = state == IDLE && bus.wr_en;
    start = state == SELECT && found;
    step = state == SEND && !last_beat;
    done = state == SEND && last_beat;
    nb = start ? 3'd0 : bus.core_addr_in + 3'd1;
    state_nx = accept ? SELECT : start ? SEND : done ? IDLE : state;
  end
  always_ff @(posedge CLK) begin
    if (rst) begin
      state <= IDLE;
      cand <= '0;
      pending <= '0;
      last_grant <= GW'(NUM_CORES - 1);
      grant <= '0;
      bus.core_wr_en <= '0;
      bus.core_din <= '0;
      bus.core_addr_in <= '0;
      num_dispatched <= '0;
      idle <= 1'b0;
      error <= '0;
    end else begin
      state <= state_nx;
      if (accept) cand <= bus.din;
      if (start) grant <= pick;
      if (done) last_grant <= grant;
      if (start || step) begin
        bus.core_addr_in <= nb;
        bus.core_din <= DIN_WIDTH'(cand >> (int'(nb) * DIN_WIDTH));
      end
      bus.core_wr_en <= start ? (NUM_CORES'(1) << pick) : step ? bus.core_wr_en : '0;
      // a fresh load outranks a concurrent ready-low clear
      pending <= (pending & bus.crypt_ready_out) | (done ? (NUM_CORES'(1) << grant) : '0);
      num_dispatched <= num_dispatched + 32'(done);
      idle <= state == IDLE && pending == '0 && &(bus.core_idle_out | DUMMY_CORES);
      error <= error | {state == SELECT && &DUMMY_CORES, |(bus.core_err_out & ~DUMMY_CORES)};
    end
  end
endmodule

// File: tb/tb_descrypt_core_dispatch.sv
// tb_descrypt_core_dispatch: directed plus randomized loads checked against a round-robin transaction model
module tb_descrypt_core_dispatch;
  localparam int NC = 4, DW = 8, NB = 4;
  logic CLK = 1'b0;
  logic rst;
  logic [NC-1:0] dummy;
  logic [31:0] num_dispatched;
  logic idle;
  logic [1:0] error;
  int n_chk = 0, n_fail = 0, m_last, m_count;
  int grants[$];
  int exp_rr[5] = '{0, 1, 3, 0, 1};
  descrypt_core_dispatch_if #(.NUM_CORES(NC), .DIN_WIDTH(DW), .NUM_BEATS(NB)) bus();
  descrypt_core_dispatch #(.NUM_CORES(NC), .DIN_WIDTH(DW), .NUM_BEATS(NB)) dut (
    .CLK(CLK), .rst(rst), .DUMMY_CORES(dummy), .bus(bus),
    .num_dispatched(num_dispatched), .idle(idle), .error(error)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  function automatic int next_grant(input logic [NC-1:0] rdy);
    logic [NC-1:0] elig;
    int g;
    elig = rdy & ~dummy;
    for (int i = 1; i <= NC; i++) begin
      g = (m_last + i) % NC;
      if (((elig >> g) & 4'd1) != 4'd0) return g;
    end
    return -1;
  endfunction
  task automatic do_reset(input logic [NC-1:0] d);
    rst = 1'b1;
    dummy = d;
    bus.wr_en = 1'b0;
    bus.din = '0;
    bus.crypt_ready_out = '0;
    bus.core_idle_out = '1;
    bus.core_err_out = '0;
    tick();
    tick();
    rst = 1'b0;
    m_last = NC - 1;
    m_count = 0;
  endtask
  task automatic expect_send(input logic [31:0] w, input int core);
    for (int k = 0; k < NB; k++) begin
      tick();
      bus.wr_en = 1'b0;
      check("beat_wr_en", bus.core_wr_en, 32'(1) << core);
      check("beat_addr", bus.core_addr_in, k);
      check("beat_din", bus.core_din, (w >> (8 * k)) & 32'hFF);
    end
    tick();
    m_count++;
    m_last = core;
    grants.push_back(core);
    check("done_full", bus.full, 0);
    check("done_wr_en", bus.core_wr_en, 0);
    check("num_dispatched", num_dispatched, m_count);
  endtask
  task automatic load(input logic [31:0] w, input int delay, input logic [NC-1:0] rdy);
    bus.crypt_ready_out = '0;
    bus.wr_en = 1'b1;
    bus.din = w;
    tick();
    bus.wr_en = 1'b0;
    check("accept_full", bus.full, 1);
    for (int i = 0; i < delay; i++) begin
      tick();
      bus.wr_en = 1'b0;
      check("blocked_full", bus.full, 1);
      check("blocked_wr_en", bus.core_wr_en, 0);
      if (i == 1 && i < delay - 1) begin
        bus.wr_en = 1'b1;
        bus.din = ~w;
      end
    end
    bus.crypt_ready_out = rdy;
    expect_send(w, next_grant(rdy));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    do_reset('0);
    check("rst_full", bus.full, 0);
    check("rst_wr_en", bus.core_wr_en, 0);
    check("rst_din", bus.core_din, 0);
    check("rst_addr", bus.core_addr_in, 0);
    check("rst_num", num_dispatched, 0);
    check("rst_error", error, 0);
    check("rst_idle", idle, 0);
    tick();
    check("idle_after_rst", idle, 1);
    load(32'hDDCCBBAA, 0, '1);
    check("single_core0", grants[0], 0);
    load(32'h12345678, 10, '1);
    // hold-off: core 0 alone stays ready after its load
    load(32'hCAFEF00D, 0, 4'b0001);
    bus.wr_en = 1'b1;
    bus.din = 32'hA5A55A5A;
    tick();
    bus.wr_en = 1'b0;
    check("hold_full", bus.full, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_full_wait", bus.full, 1);
      check("hold_wr_en", bus.core_wr_en, 0);
    end
    bus.crypt_ready_out = '0;
    tick();
    check("hold_drop_full", bus.full, 1);
    bus.crypt_ready_out = 4'b0001;
    expect_send(32'hA5A55A5A, 0);
    tick();
    check("idle_pending", idle, 0);
    bus.crypt_ready_out = '0;
    tick();
    tick();
    check("idle_cleared", idle, 1);
    do_reset(4'b0100);
    grants.delete();
    for (int i = 0; i < 5; i++) load($urandom, 0, '1);
    for (int i = 0; i < 5; i++) check("rr_grant", grants[i], exp_rr[i]);
    bus.crypt_ready_out = '0;
    bus.core_err_out = 4'b0100;
    bus.core_idle_out = 4'b1011;
    tick();
    bus.core_err_out = '0;
    tick();
    check("dummy_err_ignored", error, 0);
    check("idle_dummy_busy", idle, 1);
    bus.core_idle_out = 4'b1101;
    tick();
    check("idle_core_busy", idle, 0);
    bus.core_idle_out = '1;
    bus.core_err_out = 4'b0010;
    tick();
    bus.core_err_out = '0;
    check("core_err", error, 2'b01);
    for (int i = 0; i < 3; i++) tick();
    check("core_err_sticky", error, 2'b01);
    do_reset(4'b1111);
    check("err_rst_clear", error, 0);
    bus.crypt_ready_out = '1;
    bus.wr_en = 1'b1;
    bus.din = 32'h01020304;
    tick();
    bus.wr_en = 1'b0;
    tick();
    check("no_core_err", error, 2'b10);
    for (int i = 0; i < 3; i++) tick();
    check("no_core_full", bus.full, 1);
    check("no_core_wr_en", bus.core_wr_en, 0);
    do_reset('0);
    bus.wr_en = 1'b1;
    bus.din = 32'h11223344;
    tick();
    bus.wr_en = 1'b0;
    bus.crypt_ready_out = '1;
    tick();
    tick();
    check("mid_beat1", bus.core_addr_in, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_last = NC - 1;
    m_count = 0;
    check("mid_rst_wr_en", bus.core_wr_en, 0);
    check("mid_rst_full", bus.full, 0);
    check("mid_rst_num", num_dispatched, 0);
    load(32'h55667788, 0, '1);
    check("mid_rst_core0", grants[grants.size() - 1], 0);
    for (int r = 0; r < 5; r++) begin
      do_reset(4'($urandom_range(0, 14)));
      for (int j = 0; j < 4; j++) load($urandom, $urandom_range(0, 3), '1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
